// File: rtl/exec_unit.sv
// RV32/RV64 execute stage: ALU, branch/jump resolution, optional M extension, registered output.
// Optional multiply/divide hardware is built only when EXEC_UNIT_M_EXT_EN is defined.
//
// state | meaning
// IDLE  | no op in progress
// DIV   | iterative divide running (counter counts down to 0, then result cycle)
// HOLD  | out_valid=1, waiting for out_ready
module exec_unit #(
  parameter int XLEN = 32,
  parameter int OP_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_next_pc,
  input  logic [XLEN-1:0] in_jump_pc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_illegal
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_PASSB = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_JUMP  = OP_W'(17);
`ifdef EXEC_UNIT_M_EXT_EN
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(18);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(20);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(21);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(22);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(24);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(25);
  localparam int CNT_W = $clog2(XLEN + 1);
`endif

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  state_t state, state_nxt;
  logic   accept;

  logic [XLEN-1:0] dec_result;
  logic            dec_redirect;
  logic [XLEN-1:0] dec_redirect_pc;
  logic            dec_illegal;
  logic            dec_is_div;
  logic            dec_div_signed;
  logic            dec_div_rem;

  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic [4:0]      div_rd;

  logic [SHW-1:0]  shamt;
  logic            cmp_eq, cmp_lt, cmp_ltu;

  assign shamt   = in_b[SHW-1:0];
  assign cmp_eq  = (in_a == in_b);
  assign cmp_lt  = ($signed(in_a) < $signed(in_b));
  assign cmp_ltu = (in_a < in_b);
  assign accept  = in_valid & in_ready & ~flush;
  assign out_valid = (state == HOLD);

`ifdef EXEC_UNIT_M_EXT_EN
  // Operands widened by one bit so one signed multiplier covers all four variants.
  logic [XLEN:0]            mul_a_ext, mul_b_ext;
  logic signed [2*XLEN+1:0] mul_full;

  assign mul_a_ext = {((in_op == OP_MULH) || (in_op == OP_MULHSU)) & in_a[XLEN-1], in_a};
  assign mul_b_ext = {(in_op == OP_MULH) & in_b[XLEN-1], in_b};
  assign mul_full  = $signed(mul_a_ext) * $signed(mul_b_ext);
`endif

  always_comb begin
    dec_result      = '0;
    dec_redirect    = 1'b0;
    dec_redirect_pc = '0;
    dec_illegal     = 1'b0;
    dec_is_div      = 1'b0;
    dec_div_signed  = 1'b0;
    dec_div_rem     = 1'b0;
    case (in_op)
      OP_ADD:   dec_result = in_a + in_b;
      OP_SUB:   dec_result = in_a - in_b;
      OP_SLL:   dec_result = in_a << shamt;
      OP_SLT:   dec_result = {{(XLEN-1){1'b0}}, cmp_lt};
      OP_SLTU:  dec_result = {{(XLEN-1){1'b0}}, cmp_ltu};
      OP_XOR:   dec_result = in_a ^ in_b;
      OP_SRL:   dec_result = in_a >> shamt;
      OP_SRA:   dec_result = $signed(in_a) >>> shamt;
      OP_OR:    dec_result = in_a | in_b;
      OP_AND:   dec_result = in_a & in_b;
      OP_PASSB: dec_result = in_b;
      OP_BEQ:   dec_redirect = cmp_eq;
      OP_BNE:   dec_redirect = ~cmp_eq;
      OP_BLT:   dec_redirect = cmp_lt;
      OP_BGE:   dec_redirect = ~cmp_lt;
      OP_BLTU:  dec_redirect = cmp_ltu;
      OP_BGEU:  dec_redirect = ~cmp_ltu;
      OP_JUMP: begin
        dec_result      = in_next_pc;
        dec_redirect    = 1'b1;
        dec_redirect_pc = {in_jump_pc[XLEN-1:1], 1'b0};
      end
`ifdef EXEC_UNIT_M_EXT_EN
      OP_MUL:    dec_result = mul_full[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  dec_result = mul_full[2*XLEN-1:XLEN];
      OP_DIV:  begin dec_is_div = 1'b1; dec_div_signed = 1'b1; end
      OP_DIVU: begin dec_is_div = 1'b1; end
      OP_REM:  begin dec_is_div = 1'b1; dec_div_signed = 1'b1; dec_div_rem = 1'b1; end
      OP_REMU: begin dec_is_div = 1'b1; dec_div_rem = 1'b1; end
`endif
      default: dec_illegal = 1'b1;
    endcase
    if ((in_op >= OP_BEQ) && (in_op <= OP_BGEU) && dec_redirect)
      dec_redirect_pc = in_jump_pc;
  end

`ifdef EXEC_UNIT_M_EXT_EN
  logic [XLEN-1:0]  div_quo, div_rem, div_dvs, div_dvd;
  logic [XLEN-1:0]  div_abs_a, div_abs_b, div_quo_fix, div_rem_fix;
  logic [XLEN:0]    div_shift, div_diff;
  logic             div_ge;
  logic             div_neg_q, div_neg_r, div_zero, div_is_rem;
  logic [CNT_W-1:0] div_cnt;

  assign div_abs_a = (dec_div_signed & in_a[XLEN-1]) ? -in_a : in_a;
  assign div_abs_b = (dec_div_signed & in_b[XLEN-1]) ? -in_b : in_b;
  assign div_shift = {div_rem, div_quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, div_dvs};
  assign div_ge    = ~div_diff[XLEN];
  assign div_done  = (state == DIV) && (div_cnt == '0);

  assign div_quo_fix = div_neg_q ? -div_quo : div_quo;
  assign div_rem_fix = div_neg_r ? -div_rem : div_rem;
  // Divide by zero bypasses the sign fix-up: quotient all-ones, remainder is the raw dividend.
  assign div_result  = div_zero ? (div_is_rem ? div_dvd : '1)
                                : (div_is_rem ? div_rem_fix : div_quo_fix);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_quo    <= '0;
      div_rem    <= '0;
      div_dvs    <= '0;
      div_dvd    <= '0;
      div_neg_q  <= 1'b0;
      div_neg_r  <= 1'b0;
      div_zero   <= 1'b0;
      div_is_rem <= 1'b0;
      div_rd     <= '0;
      div_cnt    <= '0;
    end else if (flush) begin
      div_cnt <= '0;
    end else if (accept && dec_is_div) begin
      div_quo    <= div_abs_a;
      div_rem    <= '0;
      div_dvs    <= div_abs_b;
      div_dvd    <= in_a;
      div_neg_q  <= dec_div_signed & (in_a[XLEN-1] ^ in_b[XLEN-1]);
      div_neg_r  <= dec_div_signed & in_a[XLEN-1];
      div_zero   <= (in_b == '0);
      div_is_rem <= dec_div_rem;
      div_rd     <= in_rd;
      div_cnt    <= CNT_W'(XLEN);
    end else if ((state == DIV) && (div_cnt != '0)) begin
      div_rem <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
      div_quo <= {div_quo[XLEN-2:0], div_ge};
      div_cnt <= div_cnt - 1'b1;
    end
  end
`else
  assign div_done   = 1'b0;
  assign div_result = '0;
  assign div_rd     = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = dec_is_div ? DIV : HOLD;
      end
      HOLD: begin
        in_ready = out_ready;
        if (accept)         state_nxt = dec_is_div ? DIV : HOLD;
        else if (out_ready) state_nxt = IDLE;
      end
      DIV: begin
        if (div_done) state_nxt = HOLD;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result      <= '0;
      out_rd          <= '0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_result      <= '0;
      out_rd          <= '0;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
    end else if (accept && !dec_is_div) begin
      out_result      <= dec_result;
      out_rd          <= in_rd;
      out_redirect    <= dec_redirect;
      out_redirect_pc <= dec_redirect_pc;
      out_illegal     <= dec_illegal;
    end else if (div_done) begin
      out_result      <= div_result;
      out_rd          <= div_rd;
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
    end else if ((state == HOLD) && out_ready) begin
      // Drained without a new single-cycle result: drop stale redirect/illegal flags.
      out_redirect    <= 1'b0;
      out_redirect_pc <= '0;
      out_illegal     <= 1'b0;
    end
  end

endmodule
